// File: rtl/mvu_ctrl_dma_pkg.sv
// Shared types for the MVU controller-port DMA: FSM state encoding and transfer direction codes.
package mvu_dma_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic DIR_WR = 1'b0;
   localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/mvu_ctrl_dma_if.sv
// Command, host-stream and MVU wrc/rdc port bundle for mvu_ctrl_dma.
// cmd_stride exists only when MVU_DMA_STRIDE_EN is defined.
interface mvu_ctrl_dma_if #(
   parameter int N       = 64,
   parameter int BDBANKA = 15,
   parameter int BLEN    = 15
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_dir;
   logic [BDBANKA-1:0] cmd_addr;
   logic [BLEN-1:0]    cmd_len;
`ifdef MVU_DMA_STRIDE_EN
   logic [BLEN-1:0]    cmd_stride;
`endif
   logic               busy;
   logic               done;

   logic               s_valid;
   logic               s_ready;
   logic [N-1:0]       s_word;
   logic               m_valid;
   logic               m_ready;
   logic [N-1:0]       m_word;

   logic               wrc_en;
   logic               wrc_grnt;
   logic [BDBANKA-1:0] wrc_addr;
   logic [N-1:0]       wrc_word;
   logic               rdc_en;
   logic               rdc_grnt;
   logic [BDBANKA-1:0] rdc_addr;
   logic [N-1:0]       rdc_word;

   // master = the DMA engine, slave = host plus MVU side
   modport master (
`ifdef MVU_DMA_STRIDE_EN
      input  cmd_stride,
`endif
      input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
      output cmd_ready, busy, done,
      input  s_valid, s_word, m_ready, wrc_grnt, rdc_grnt, rdc_word,
      output s_ready, m_valid, m_word,
      output wrc_en, wrc_addr, wrc_word, rdc_en, rdc_addr
   );

   modport slave (
`ifdef MVU_DMA_STRIDE_EN
      output cmd_stride,
`endif
      output cmd_valid, cmd_dir, cmd_addr, cmd_len,
      input  cmd_ready, busy, done,
      output s_valid, s_word, m_ready, wrc_grnt, rdc_grnt, rdc_word,
      input  s_ready, m_valid, m_word,
      input  wrc_en, wrc_addr, wrc_word, rdc_en, rdc_addr
   );

endinterface

// File: rtl/mvu_ctrl_dma_fifo.sv
// Read-return FIFO: power-of-two depth, occupancy count, head word reads as zero while empty.
module mvu_dma_fifo #(
   parameter int N     = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [N-1:0] push_word,
   input  logic         pop,
   output logic [N-1:0] pop_word,
   output logic [AW:0]  count,
   output logic         empty
);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign empty    = (count == '0);
   assign pop_word = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_word;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL));

endmodule

// File: rtl/mvu_ctrl_dma.sv
// Host-side DMA initiator moving word blocks between host streams and one MVU data memory.
// Define MVU_DMA_STRIDE_EN to add a latched per-command address stride; otherwise stride is 1.
module mvu_ctrl_dma
   import mvu_dma_pkg::*;
#(
   parameter int N       = 64,
   parameter int BDBANKA = 15,
   parameter int BLEN    = 15,
   parameter int RDLAT   = 1,
   parameter int DEPTH   = 4
) (
   input logic            clk,
   input logic            rst_n,
   mvu_ctrl_dma_if.master bus
);
   localparam int CW = $clog2(DEPTH);
   localparam logic [CW+1:0] DEPTH_W = DEPTH[CW+1:0];

   state_t             state;
   logic [BLEN-1:0]    len_q;
   logic [BLEN-1:0]    cnt_a;     // WR: words accepted, RD: requests granted
   logic [BLEN-1:0]    cnt_b;     // WR: writes granted,  RD: words delivered
   logic [BDBANKA-1:0] wr_next;
   logic [BDBANKA-1:0] step;
   logic [RDLAT-1:0]   vpipe;
   logic [CW:0]        fifo_count;
   logic [CW:0]        inflight;
   logic [CW+1:0]      occ;
   logic               fifo_empty;
   logic               s_hs;
   logic               w_xfer;
   logic               r_xfer;
   logic               m_hs;

`ifdef MVU_DMA_STRIDE_EN
   logic [BLEN-1:0]    stride_q;
   assign step = BDBANKA'(stride_q);
`else
   assign step = {{(BDBANKA-1){1'b0}}, 1'b1};
`endif

   // Reserving FIFO room at request time guarantees every return has a slot.
   assign inflight    = (CW+1)'($countones(vpipe));
   assign occ         = {1'b0, fifo_count} + {1'b0, inflight};

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.s_ready   = (state == WR) && (cnt_a < len_q) && (!bus.wrc_en || bus.wrc_grnt);
   assign bus.rdc_en    = (state == RD) && (cnt_a < len_q) && (occ < DEPTH_W);
   assign bus.m_valid   = !fifo_empty;

   assign s_hs   = bus.s_valid && bus.s_ready;
   assign w_xfer = bus.wrc_en && bus.wrc_grnt;
   assign r_xfer = bus.rdc_en && bus.rdc_grnt;
   assign m_hs   = bus.m_valid && bus.m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len_q        <= '0;
         cnt_a        <= '0;
         cnt_b        <= '0;
         wr_next      <= '0;
         vpipe        <= '0;
         bus.wrc_en   <= 1'b0;
         bus.wrc_addr <= '0;
         bus.wrc_word <= '0;
         bus.rdc_addr <= '0;
`ifdef MVU_DMA_STRIDE_EN
         stride_q     <= '0;
`endif
      end else begin
         vpipe[0] <= r_xfer;
         for (int i = 1; i < RDLAT; i++) vpipe[i] <= vpipe[i-1];

         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  len_q        <= bus.cmd_len;
                  cnt_a        <= '0;
                  cnt_b        <= '0;
                  wr_next      <= bus.cmd_addr;
                  bus.rdc_addr <= bus.cmd_addr;
`ifdef MVU_DMA_STRIDE_EN
                  stride_q     <= bus.cmd_stride;
`endif
                  if (bus.cmd_len == '0)        state <= DONE;
                  else if (bus.cmd_dir == DIR_RD) state <= RD;
                  else                            state <= WR;
               end
            end
            WR: begin
               if (s_hs) begin
                  bus.wrc_en   <= 1'b1;
                  bus.wrc_addr <= wr_next;
                  bus.wrc_word <= bus.s_word;
                  wr_next      <= wr_next + step;
                  cnt_a        <= cnt_a + 1'b1;
               end else if (w_xfer) begin
                  bus.wrc_en <= 1'b0;
               end
               if (w_xfer) begin
                  cnt_b <= cnt_b + 1'b1;
                  if (cnt_b + 1'b1 == len_q) state <= DONE;
               end
            end
            RD: begin
               if (r_xfer) begin
                  bus.rdc_addr <= bus.rdc_addr + step;
                  cnt_a        <= cnt_a + 1'b1;
               end
               if (m_hs) begin
                  cnt_b <= cnt_b + 1'b1;
                  if (cnt_b + 1'b1 == len_q) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   mvu_dma_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (vpipe[RDLAT-1]),
      .push_word (bus.rdc_word),
      .pop       (m_hs),
      .pop_word  (bus.m_word),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule
